hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/fwd_sel.sv | 30 +++
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and defaults for the pipeline hazard controller
// Revision   : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int WAIT_CNT_W         = 8;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// ============================================================================
// fwd_sel : ALU operand bypass select for one Execute-stage source register
// Revision: 1.0
// ============================================================================
`default_nettype none

module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output fwd_sel_t   sel_o
);

  // Memory-stage result is newer than Writeback, so it takes priority.
  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i)) begin
      sel_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : forwarding, load-use/branch hazards and data-memory wait FSM.
//               Optional performance counters enabled by HAZARD_PERF_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic [4:0]  rs1_E,
  input  logic [4:0]  rs2_E,
  input  logic [4:0]  rd_E,
  input  logic [4:0]  rd_M,
  input  logic [4:0]  rd_W,
  input  logic        regWrite_M,
  input  logic        regWrite_W,
  input  logic        load_E,
  input  logic        pcSrc_E,
  input  logic        memReq_M,
  input  logic        memAck,
  output logic [1:0]  forwardA_E,
  output logic [1:0]  forwardB_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_E,
  output logic        stall_E,
  output logic        stall_M,
  output logic        memErr,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_L = WAIT_CNT_W'(TIMEOUT_CYCLES);

  fwd_sel_t                w_fwd_a;
  fwd_sel_t                w_fwd_b;
  logic                    w_lw_stall;
  logic                    w_mem_stall;
  mem_state_t              state_q;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q;
  logic                    mem_err_q;

  fwd_sel u_fwd_a (
    .rs_i          (rs1_E),
    .rd_m_i        (rd_M),
    .rd_w_i        (rd_W),
    .reg_write_m_i (regWrite_M),
    .reg_write_w_i (regWrite_W),
    .sel_o         (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_i          (rs2_E),
    .rd_m_i        (rd_M),
    .rd_w_i        (rd_W),
    .reg_write_m_i (regWrite_M),
    .reg_write_w_i (regWrite_W),
    .sel_o         (w_fwd_b)
  );

  assign forwardA_E = w_fwd_a;
  assign forwardB_E = w_fwd_b;

  assign w_lw_stall = load_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Same-cycle memAck in IDLE costs nothing; ERR freezes the pipe until reset.
  assign w_mem_stall = ((state_q == IDLE) && memReq_M && !memAck) ||
                       ((state_q == WAIT) && !memAck) ||
                       (state_q == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (memReq_M && !memAck) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (memAck) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (wait_cnt_q == TIMEOUT_L) begin
              state_q   <= ERR;
              mem_err_q <= 1'b1;
            end
          end
        end
        ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          mem_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign memErr = mem_err_q;

  // A pending branch flush is held off while memory stalls the whole pipe.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (w_mem_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
    end else begin
      flush_D = pcSrc_E;
      flush_E = pcSrc_E || w_lw_stall;
      stall_F = w_lw_stall && !pcSrc_E;
      stall_D = w_lw_stall && !pcSrc_E;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_F && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if ((flush_D || flush_E) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : table-driven and sequence checks for hazard_ctrl
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs1_D = '0, rs2_D = '0, rs1_E = '0, rs2_E = '0;
  logic [4:0]  rd_E = '0, rd_M = '0, rd_W = '0;
  logic        regWrite_M = 1'b0, regWrite_W = 1'b0, load_E = 1'b0;
  logic        pcSrc_E = 1'b0, memReq_M = 1'b0, memAck = 1'b0;
  logic [1:0]  forwardA_E, forwardB_E;
  logic        stall_F, stall_D, flush_D, flush_E, stall_E, stall_M, memErr;
  logic [31:0] stallCount, flushCount;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1_D      (rs1_D),
    .rs2_D      (rs2_D),
    .rs1_E      (rs1_E),
    .rs2_E      (rs2_E),
    .rd_E       (rd_E),
    .rd_M       (rd_M),
    .rd_W       (rd_W),
    .regWrite_M (regWrite_M),
    .regWrite_W (regWrite_W),
    .load_E     (load_E),
    .pcSrc_E    (pcSrc_E),
    .memReq_M   (memReq_M),
    .memAck     (memAck),
    .forwardA_E (forwardA_E),
    .forwardB_E (forwardB_E),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .flush_E    (flush_E),
    .stall_E    (stall_E),
    .stall_M    (stall_M),
    .memErr     (memErr),
    .stallCount (stallCount),
    .flushCount (flushCount)
  );

  // ctl = {regWrite_M, regWrite_W, load_E, pcSrc_E, memReq_M, memAck}
  // exp = {fwdA[1:0], fwdB[1:0], stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
  typedef struct {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [5:0] ctl;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [9:0] outs();
    return {forwardA_E, forwardB_E, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1_D = v.rs1_D; rs2_D = v.rs2_D; rs1_E = v.rs1_E; rs2_E = v.rs2_E;
    rd_E = v.rd_E; rd_M = v.rd_M; rd_W = v.rd_W;
    {regWrite_M, regWrite_W, load_E, pcSrc_E, memReq_M, memAck} = v.ctl;
  endtask

  task automatic idle();
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0;
    rd_E = '0; rd_M = '0; rd_W = '0;
    {regWrite_M, regWrite_W, load_E, pcSrc_E, memReq_M, memAck} = 6'b0;
  endtask

  task automatic load_use();
    idle();
    load_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 6'b110000, 10'b10_00_0000_00};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 6'b110000, 10'b01_00_0000_00};
    vecs[2]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 6'b010000, 10'b01_01_0000_00};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'b110000, 10'b00_00_0000_00};
    vecs[4]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd4, 6'b110000, 10'b10_10_0000_00};
    vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 6'b001000, 10'b00_00_1100_01};
    vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 6'b001100, 10'b00_00_0000_11};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'b001000, 10'b00_00_0000_00};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 6'b000000, 10'b00_00_0000_00};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'b000100, 10'b00_00_0000_11};
    vecs[10] = '{5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 6'b100011, 10'b10_00_0000_00};
    vecs[11] = '{5'd6, 5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd6, 6'b011000, 10'b00_01_1100_01};

    // Reset asserted: outputs evaluate with the FSM in IDLE
    idle();
    memReq_M = 1'b1;
    #2;
    check("rst_outs", 32'(outs()), 32'b00_00_1111_00);
    check("rst_memErr", 32'(memErr), 32'd0);
    check("rst_stallCount", stallCount, 32'd0);
    check("rst_flushCount", flushCount, 32'd0);
    @(negedge clk);
    idle();
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Three-cycle memory wait with a taken branch held behind it
    @(negedge clk);
    load_use();
    pcSrc_E = 1'b1; memReq_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("memwait%0d", i), 32'(outs()), 32'b00_00_1111_00);
      @(negedge clk);
    end
    memAck = 1'b1;
    #2;
    check("memack", 32'(outs()), 32'b00_00_0000_11);
    @(negedge clk);
    idle();
    #2;
    check("mem_back_idle", 32'(outs()), 32'd0);

    // Timeout: 5 WAIT cycles then ERR, sticky until reset
    @(negedge clk);
    memReq_M = 1'b1;
    #2;
    check("to_c0_memErr", 32'(memErr), 32'd0);
    repeat (5) @(negedge clk);
    #2;
    check("to_c5_memErr", 32'(memErr), 32'd0);
    @(negedge clk);
    #2;
    check("to_c6_memErr", 32'(memErr), 32'd1);
    @(negedge clk);
    memReq_M = 1'b0; memAck = 1'b1; pcSrc_E = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("err_sticky", 32'(memErr), 32'd1);
    check("err_outs", 32'(outs()), 32'b00_00_1111_00);
    reset = 1'b0;
    #1;
    check("err_rst_memErr", 32'(memErr), 32'd0);
    check("err_rst_outs", 32'(outs()), 32'b00_00_0000_11);
    @(negedge clk);
    reset = 1'b1;
    idle();
    #2;
    check("err_release_idle", 32'(outs()), 32'd0);

    // Reset during WAIT aborts the wait
    @(negedge clk);
    memReq_M = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("wait_before_rst", 32'(outs()), 32'b00_00_1111_00);
    reset = 1'b0;
    memReq_M = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("wait_rst_idle", 32'(outs()), 32'd0);

    // Counters: 3 load-use stalls and 2 branches from a clean reset
    @(negedge clk);
    idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    load_use();
    repeat (3) @(negedge clk);
    idle();
    pcSrc_E = 1'b1;
    repeat (2) @(negedge clk);
    idle();
    #2;
`ifdef HAZARD_PERF_EN
    check("perf_stallCount", stallCount, 32'd3);
    check("perf_flushCount", flushCount, 32'd5);
`else
    check("perf_stallCount", stallCount, 32'd0);
    check("perf_flushCount", flushCount, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
